rcon_sequencer: RTL and testbench
=================================

Name: rcon_sequencer

Overview:
- Sequential round-constant generator for the AES key-expansion datapath. Replaces the fixed 10-entry lookup.
- Walks every expanded-key word index for AES-128/192/256 and presents one word per handshake: index, 32-bit Rcon word, and the per-word transform flags.
- Supports a forward (encryption) walk and a reverse (decryption, on-the-fly inverse key schedule) walk.
- Rcon bytes are computed with GF(2^8) xtime / inverse-xtime, not stored.

Parameters:
- KEY_BITS, 128, key size; legal values 128, 192, 256. Any other value is an elaboration error.
- NK, KEY_BITS/32, key words (4/6/8); derived, not overridable.
- NR, NK+6, round count; derived.
- TOTAL, 4*(NR+1), expanded-key word count (44/52/60); derived.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a walk; ignored unless idle
- mode  in  1  0 = forward, 1 = reverse; sampled only when start is accepted
- out_ready  in  1  consumer accepts current word
- out_valid  out  1  word_idx/rcon/flags are valid
- word_idx  out  6  expanded-key word index i
- rcon  out  32  {rc_byte, 24'h0} when rot_word=1, else 32'h0
- rot_word  out  1  i mod NK == 0 (RotWord+SubWord+Rcon)
- sub_only  out  1  NK==8 and i mod 8 == 4 (SubWord only)
- last  out  1  current word is the final word of the walk
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; out_valid, busy, done, last, rot_word, sub_only = 0; word_idx=0; rcon=0.
  - Reset mid-walk aborts the walk immediately. There is no resume.
- FSM:
  - IDLE: start=1 -> RUN, busy=1.
  - RUN: on accept (out_valid & out_ready) with last=1 -> DONE.
  - DONE: done=1, out_valid=0, busy=0 for exactly one cycle -> IDLE.
  - start is ignored in RUN and DONE.
- Latency: start accepted at edge t -> out_valid=1 with the first word after edge t (visible in cycle t+1). Back-to-back accepts give one word per cycle.
- Handshake:
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - out_valid stays high throughout RUN; it never drops without an accept.
  - out_ready is ignored when out_valid=0.
- Registers:
  - idx (6b).
  - phase (0..NK-1, always equal to idx mod NK; no divider).
  - rc (8b).
  - dir (latched mode).
- Forward walk:
  - Start: idx=NK, phase=0, rc=8'h01.
  - On accept: idx+1; phase+1, wrapping NK-1 -> 0.
  - On accept of a rot_word: rc=xtime(rc) = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1b : 8'h00).
  - last when idx==TOTAL-1.
- Reverse walk:
  - Start: idx=TOTAL-1, phase=3 (holds for all three key sizes), rc = final forward rc: 8'h36 / 8'h80 / 8'h40 for NK=4/6/8.
  - On accept: idx-1; phase-1, wrapping 0 -> NK-1.
  - On accept of a rot_word: rc=inv_xtime(rc) = rc[0] ? ((rc^8'h1b)>>1)|8'h80 : rc>>1.
  - last when idx==NK.
- Rot words: forward and reverse emit identical (word_idx, rcon) pairs. Only the order differs.
- Word counts: 40/46/52 words per walk. Rot words per walk: 10/8/7.
- sub_only and rot_word are never both 1. sub_only is constant 0 for NK!=8.
- Simultaneous start and reset: reset wins.
- A start in the DONE cycle is dropped. A start in the cycle after DONE is accepted.

Test Plan:
- KEY_BITS=128, fwd, out_ready=1: start -> 40 consecutive words, idx 4..43. rcon nonzero only at idx 4,8,...,40 with bytes 01,02,04,08,10,20,40,80,1b,36. last at idx 43, done pulse next cycle.
- KEY_BITS=128, rev: first word idx 43 with rcon=0. idx 40 has rcon=32'h36000000, idx 36 has 32'h1b000000, ... idx 4 has 32'h01000000. last at idx 4.
- KEY_BITS=256, fwd: sub_only=1 at idx 12,20,...,52; rot_word at 8,...,56 with 01..40. Total 52 words.
- KEY_BITS=192, random out_ready back-pressure (about 50%): outputs stable whenever stalled. Sequence matches the no-stall reference (46 words, rc 01..80, final rot idx 48).
- Mid-walk reset at idx 20 -> all outputs 0 asynchronously. A new start then begins at idx NK with rc=01.
- start pulsed while busy, and in the DONE cycle -> ignored. The word sequence is unaffected and no second walk occurs.

Source files
------------

// File: rtl/rcon_sequencer_if.sv
// rtl/rcon_sequencer_if.sv - round-constant word stream from rcon_sequencer to the key-expansion datapath
interface rcon_sequencer_if;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  word_idx;
  logic [31:0] rcon;
  logic        rot_word;
  logic        sub_only;
  logic        last;

  modport master (
    output out_valid, word_idx, rcon, rot_word, sub_only, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, word_idx, rcon, rot_word, sub_only, last,
    output out_ready
  );
endinterface

// File: rtl/rcon_sequencer.sv
// rtl/rcon_sequencer.sv - AES key-expansion word walker emitting index, Rcon and transform flags
// Rcon bytes are stepped with GF(2^8) xtime / inverse xtime instead of a lookup table.
module rcon_sequencer #(
  parameter int KEY_BITS = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  rcon_sequencer_if.master out
);
  localparam int NK    = KEY_BITS / 32;
  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);

  localparam logic [5:0] IDX_FIRST = 6'(NK);
  localparam logic [5:0] IDX_LAST  = 6'(TOTAL - 1);
  localparam logic [2:0] PHASE_MAX = 3'(NK - 1);
  localparam logic [7:0] RC_FINAL  = (NK == 4) ? 8'h36 : (NK == 6) ? 8'h80 : 8'h40;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("rcon_sequencer: KEY_BITS must be 128, 192 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  phase_q, phase_d;
  logic [7:0]  rc_q, rc_d;
  logic        dir_q, dir_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        last_q, last_d;
  logic        rot_q, rot_d;
  logic        sub_q, sub_d;
  logic [31:0] rcon_q, rcon_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    rc_d    = rc_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dir_d   = mode;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          idx_d   = mode ? IDX_LAST : IDX_FIRST;
          phase_d = mode ? 3'd3 : 3'd0;
          rc_d    = mode ? RC_FINAL : 8'h01;
        end
      end
      RUN: begin
        if (valid_q && out.out_ready) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (dir_q) begin
            idx_d   = idx_q - 6'd1;
            phase_d = (phase_q == 3'd0) ? PHASE_MAX : phase_q - 3'd1;
            if (rot_q) rc_d = inv_xtime(rc_q);
          end else begin
            idx_d   = idx_q + 6'd1;
            phase_d = (phase_q == PHASE_MAX) ? 3'd0 : phase_q + 3'd1;
            if (rot_q) rc_d = xtime(rc_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flags are derived from the next position so they leave the flops aligned with it.
    rot_d  = valid_d && (phase_d == 3'd0);
    sub_d  = valid_d && (NK == 8) && (phase_d == 3'd4);
    last_d = valid_d && (dir_d ? (idx_d == IDX_FIRST) : (idx_d == IDX_LAST));
    rcon_d = rot_d ? {rc_d, 24'h0} : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      rc_q    <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      rot_q   <= 1'b0;
      sub_q   <= 1'b0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      rc_q    <= rc_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
      rot_q   <= rot_d;
      sub_q   <= sub_d;
      rcon_q  <= rcon_d;
    end
  end

  assign out.out_valid = valid_q;
  assign out.word_idx  = idx_q;
  assign out.rcon      = rcon_q;
  assign out.rot_word  = rot_q;
  assign out.sub_only  = sub_q;
  assign out.last      = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_rcon_sequencer.sv
// tb/tb_rcon_sequencer.sv - self-checking bench for rcon_sequencer at all three key sizes
module tb_rcon_sequencer;
  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] rcon;
    logic        rot;
    logic        sub;
    logic        last;
  } word_t;

  typedef struct {
    int         k;
    bit         m;
    int         stall;
    bit         inject;
    int         n_words;
    int         n_rots;
    logic [5:0] first_idx;
    logic [5:0] last_idx;
    logic [7:0] first_rc;
    logic [7:0] last_rc;
  } case_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_a, mode_a, ready_a;
  logic [2:0]  valid_a, busy_a, done_a;
  word_t [2:0] w_a;

  int n_checks = 0;
  int n_fail   = 0;

  word_t cap_q[$];
  word_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rcon_sequencer_if bus ();
    rcon_sequencer #(.KEY_BITS(128 + 64 * g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_a[g]),
      .mode  (mode_a[g]),
      .busy  (busy_a[g]),
      .done  (done_a[g]),
      .out   (bus)
    );
    assign bus.out_ready = ready_a[g];
    assign valid_a[g]    = bus.out_valid;
    assign w_a[g]        = {bus.word_idx, bus.rcon, bus.rot_word, bus.sub_only, bus.last};
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: Rcon for round j is 2^(j-1) in GF(2^8); reverse walk is the forward list backwards.
  function automatic logic [7:0] gf_pow2(input int e);
    logic [7:0] b = 8'h01;
    for (int i = 0; i < e; i++) b = (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
    return b;
  endfunction

  task automatic build_exp(input int nk, input bit m);
    word_t fwd[$];
    word_t e;
    int    total = 4 * (nk + 7);
    for (int i = nk; i < total; i++) begin
      e.idx  = 6'(i);
      e.rot  = (i % nk == 0);
      e.sub  = (nk == 8) && (i % 8 == 4);
      e.rcon = e.rot ? {gf_pow2(i / nk - 1), 24'h0} : 32'h0;
      e.last = 1'b0;
      fwd.push_back(e);
    end
    exp_q.delete();
    if (m) for (int i = fwd.size() - 1; i >= 0; i--) exp_q.push_back(fwd[i]);
    else   exp_q = fwd;
    exp_q[exp_q.size() - 1].last = 1'b1;
  endtask

  task automatic run_walk(input int k, input bit m, input int stall, input bit inject);
    word_t cur, hw;
    bit    held = 0, got_last = 0, rdy;
    cap_q.delete();
    @(negedge clk);
    start_a[k] = 1'b1;
    mode_a[k]  = m;
    ready_a[k] = 1'b0;
    for (int c = 0; c < 400 && !got_last; c++) begin
      @(negedge clk);
      start_a[k] = (inject && c == 10);
      mode_a[k]  = 1'($urandom);
      check("run_valid_busy", {62'd0, valid_a[k], busy_a[k]}, 64'd3);
      if (!(valid_a[k] && busy_a[k])) break;
      cur = w_a[k];
      if (held) check("stall_hold", 64'(cur), 64'(hw));
      rdy = ($urandom_range(99) >= stall);
      ready_a[k] = rdy;
      if (rdy) begin
        cap_q.push_back(cur);
        held = 0;
        if (cur.last) got_last = 1;
      end else begin
        held = 1;
        hw   = cur;
      end
    end
    check("walk_finished", {63'd0, got_last}, 64'd1);
    @(negedge clk);
    ready_a[k] = 1'b0;
    check("done_pulse", {61'd0, done_a[k], valid_a[k], busy_a[k]}, 64'd4);
    if (inject) start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    check("done_clear", {61'd0, done_a[k], valid_a[k], busy_a[k]}, 64'd0);
    @(negedge clk);
    check("no_restart", {61'd0, done_a[k], valid_a[k], busy_a[k]}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    case_t tbl[6];
    int    rots, first_rc_seen;
    logic [7:0] frc, lrc;
    bit    found;

    tbl[0] = '{0, 1'b0,  0, 1'b0, 40, 10, 6'd4,  6'd43, 8'h01, 8'h36};
    tbl[1] = '{0, 1'b1,  0, 1'b1, 40, 10, 6'd43, 6'd4,  8'h36, 8'h01};
    tbl[2] = '{2, 1'b0,  0, 1'b0, 52,  7, 6'd8,  6'd59, 8'h01, 8'h40};
    tbl[3] = '{1, 1'b0, 50, 1'b0, 46,  8, 6'd6,  6'd51, 8'h01, 8'h80};
    tbl[4] = '{1, 1'b1, 50, 1'b1, 46,  8, 6'd51, 6'd6,  8'h80, 8'h01};
    tbl[5] = '{2, 1'b1, 30, 1'b0, 52,  7, 6'd59, 6'd8,  8'h40, 8'h01};

    rst_n = 1'b0; start_a = '0; mode_a = '0; ready_a = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ctl%0d", k), {61'd0, valid_a[k], busy_a[k], done_a[k]}, 64'd0);
      check($sformatf("reset_word%0d", k), 64'(w_a[k]), 64'd0);
    end
    rst_n = 1'b1;

    // Start coincident with reset must be lost.
    @(negedge clk);
    rst_n = 1'b0; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0; rst_n = 1'b1;
    check("reset_wins", {62'd0, valid_a[0], busy_a[0]}, 64'd0);
    @(negedge clk);
    check("reset_wins_after", {62'd0, valid_a[0], busy_a[0]}, 64'd0);

    // Asynchronous reset in the middle of a forward walk.
    start_a[0] = 1'b1; mode_a[0] = 1'b0; ready_a[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start_a[0] = 1'b0;
      if (valid_a[0] && w_a[0].idx == 6'd20) found = 1;
    end
    check("reach_idx20", {63'd0, found}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctl", {61'd0, valid_a[0], busy_a[0], done_a[0]}, 64'd0);
    check("async_reset_word", 64'(w_a[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; ready_a[0] = 1'b0;

    for (int r = 0; r < 6; r++) begin
      run_walk(tbl[r].k, tbl[r].m, tbl[r].stall, tbl[r].inject);
      build_exp(4 + 2 * tbl[r].k, tbl[r].m);
      check($sformatf("r%0d_nwords", r), 64'(cap_q.size()), 64'(tbl[r].n_words));
      check($sformatf("r%0d_model_len", r), 64'(cap_q.size()), 64'(exp_q.size()));
      rots = 0; first_rc_seen = 0; frc = '0; lrc = '0;
      for (int i = 0; i < cap_q.size(); i++) begin
        if (cap_q[i].rot) begin
          rots++;
          if (!first_rc_seen) frc = cap_q[i].rcon[31:24];
          first_rc_seen = 1;
          lrc = cap_q[i].rcon[31:24];
        end
        if (i < exp_q.size())
          check($sformatf("r%0d_word%0d", r, i), 64'(cap_q[i]), 64'(exp_q[i]));
      end
      check($sformatf("r%0d_nrots", r), 64'(rots), 64'(tbl[r].n_rots));
      check($sformatf("r%0d_first_rc", r), 64'(frc), 64'(tbl[r].first_rc));
      check($sformatf("r%0d_last_rc", r), 64'(lrc), 64'(tbl[r].last_rc));
      if (cap_q.size() > 0) begin
        check($sformatf("r%0d_first_idx", r), 64'(cap_q[0].idx), 64'(tbl[r].first_idx));
        check($sformatf("r%0d_last_idx", r), 64'(cap_q[cap_q.size() - 1].idx), 64'(tbl[r].last_idx));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
